dir_matrix_writer: RTL and testbench

Fill-phase writer for the direction matrix. It scans the N×N score matrix in row-major order and accepts one cell's neighbour scores per handshake beat. For each cell it computes the new score and its direction symbol, then writes the symbol into the direction RAM. That RAM is read during traceback. When the last cell has been written, it raises `end_f`, which the control FSM uses to enable traceback.

---
 rtl/dir_matrix_writer.sv | 204 ++++++++++++++++++++
 tb/tb_dir_matrix_writer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_matrix_writer.sv
// Fill-phase writer: scores each cell of the N x N matrix and writes its direction symbol to the direction RAM.
// Optional DIR_MULTIHOT_EN: symbol reports every direction that reaches the maximum instead of a single winner.
module dir_matrix_writer #(
    parameter int unsigned N       = 128,
    parameter int unsigned BitAddr = $clog2(N + 1),
    parameter int unsigned SW      = 10,
    parameter int          MATCH    = 1,
    parameter int          MISMATCH = -1,
    parameter int          GAP      = -1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_fill,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [SW-1:0] score_diag,
    input  logic signed [SW-1:0] score_up,
    input  logic signed [SW-1:0] score_left,
    input  logic                 match,
    output logic                 we,
    output logic [BitAddr:0]     addr_i,
    output logic [BitAddr:0]     addr_j,
    output logic [2:0]           symbol,
    output logic signed [SW-1:0] score_out,
    output logic [BitAddr:0]     i_f,
    output logic [BitAddr:0]     j_f,
    output logic                 end_f
);

    localparam int unsigned   AW   = BitAddr + 1;
    localparam logic [AW-1:0] LAST = AW'(N);
    localparam logic [2:0]    DIAG = 3'b001;
    localparam logic [2:0]    UP   = 3'b010;
    localparam logic [2:0]    LEFT = 3'b100;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t r_state, w_state_nxt;
    logic   r_abort, w_abort_nxt;
    logic   r_in_ready, r_end_f;
    logic [AW-1:0] r_i_f, r_j_f;

    logic w_accept, w_last;

    // stage 1
    logic                 r_v1;
    logic signed [SW-1:0] r_cd, r_cu, r_cl;
    logic [AW-1:0]        r_a1_i, r_a1_j;
    logic signed [SW-1:0] w_bonus;

    // stage 2
    logic                 r_we;
    logic [2:0]           r_symbol;
    logic signed [SW-1:0] r_score;
    logic [AW-1:0]        r_addr_i, r_addr_j;
    logic                 w_d_ge_u, w_d_ge_l, w_u_ge_l;
    logic signed [SW-1:0] w_max;
    logic [2:0]           w_sym;

    assign w_accept = in_valid & r_in_ready;
    assign w_last   = (r_i_f == LAST) && (r_j_f == LAST);

    assign in_ready  = r_in_ready;
    assign end_f     = r_end_f;
    assign i_f       = r_i_f;
    assign j_f       = r_j_f;
    assign we        = r_we;
    assign symbol    = r_symbol;
    assign score_out = r_score;
    assign addr_i    = r_addr_i;
    assign addr_j    = r_addr_j;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    // r_abort remembers an en_fill drop so the drain ends in IDLE rather than DONE
    always_comb begin
        w_state_nxt = r_state;
        w_abort_nxt = r_abort;
        case (r_state)
            IDLE: begin
                w_abort_nxt = 1'b0;
                if (en_fill) w_state_nxt = FILL;
            end
            FILL: begin
                if (!en_fill) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = DRAIN;
                end else if (w_accept && w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!en_fill) w_abort_nxt = 1'b1;
                // stage 1 empty now means both stages are empty after this edge
                if (!r_v1) w_state_nxt = (r_abort || !en_fill) ? IDLE : DONE;
            end
            DONE: begin
                if (!en_fill) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // registered status flags and the row-major cell counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_end_f    <= 1'b0;
            r_i_f      <= '0;
            r_j_f      <= '0;
        end else begin
            r_in_ready <= (w_state_nxt == FILL);
            r_end_f    <= (w_state_nxt == DONE);
            if (r_state == IDLE && en_fill) begin
                r_i_f <= AW'(1);
                r_j_f <= AW'(1);
            end else if (w_state_nxt == IDLE) begin
                r_i_f <= '0;
                r_j_f <= '0;
            end else if (w_accept && !w_last) begin
                if (r_j_f < LAST) begin
                    r_j_f <= r_j_f + AW'(1);
                end else begin
                    r_j_f <= AW'(1);
                    r_i_f <= r_i_f + AW'(1);
                end
            end
        end
    end

    assign w_bonus = match ? SW'(MATCH) : SW'(MISMATCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_cd   <= '0;
            r_cu   <= '0;
            r_cl   <= '0;
            r_a1_i <= '0;
            r_a1_j <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_cd   <= score_diag + w_bonus;
                r_cu   <= score_up + SW'(GAP);
                r_cl   <= score_left + SW'(GAP);
                r_a1_i <= r_i_f - AW'(1);
                r_a1_j <= r_j_f - AW'(1);
            end
        end
    end

    assign w_d_ge_u = $signed(r_cd) >= $signed(r_cu);
    assign w_d_ge_l = $signed(r_cd) >= $signed(r_cl);
    assign w_u_ge_l = $signed(r_cu) >= $signed(r_cl);

    // max with DIAG > UP > LEFT tie priority
    always_comb begin
        w_max = r_cd;
        w_sym = DIAG;
        if (w_d_ge_u && w_d_ge_l) begin
            w_max = r_cd;
            w_sym = DIAG;
        end else if (w_u_ge_l) begin
            w_max = r_cu;
            w_sym = UP;
        end else begin
            w_max = r_cl;
            w_sym = LEFT;
        end
`ifdef DIR_MULTIHOT_EN
        w_sym = {r_cl == w_max, r_cu == w_max, r_cd == w_max};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_symbol <= 3'b000;
            r_score  <= '0;
            r_addr_i <= '0;
            r_addr_j <= '0;
        end else begin
            r_we <= r_v1;
            if (r_v1) begin
                r_symbol <= w_sym;
                r_score  <= w_max;
                r_addr_i <= r_a1_i;
                r_addr_j <= r_a1_j;
            end else begin
                r_symbol <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_dir_matrix_writer.sv
// Bench for dir_matrix_writer (N=4): single-cell vector table, randomized scans against a reference model,
// abort and mid-fill reset sequences. Honours DIR_MULTIHOT_EN when defined.
module tb_dir_matrix_writer;

    localparam int N  = 4;
    localparam int BA = $clog2(N + 1);
    localparam int AW = BA + 1;
    localparam int SW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_fill = 1'b0;
    logic in_valid = 1'b0;
    logic match = 1'b0;
    logic signed [SW-1:0] score_diag = '0;
    logic signed [SW-1:0] score_up   = '0;
    logic signed [SW-1:0] score_left = '0;
    logic                 in_ready, we, end_f;
    logic [AW-1:0]        addr_i, addr_j, i_f, j_f;
    logic [2:0]           symbol;
    logic signed [SW-1:0] score_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         d, u, l;
        bit         m;
        logic [2:0] sym1;
        logic [2:0] symm;
        int         score;
    } vec_t;

    typedef struct {
        int         due;
        int         ai, aj;
        logic [2:0] sym;
        int         score;
    } exp_t;

    vec_t vt[8];

    dir_matrix_writer #(.N(N), .SW(SW)) dut (
        .clk(clk), .rst(rst), .en_fill(en_fill), .in_valid(in_valid), .in_ready(in_ready),
        .score_diag(score_diag), .score_up(score_up), .score_left(score_left), .match(match),
        .we(we), .addr_i(addr_i), .addr_j(addr_j), .symbol(symbol), .score_out(score_out),
        .i_f(i_f), .j_f(j_f), .end_f(end_f)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_err=%0d expected 0", n_err);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int wrap(input int v);
        int m;
        m = v & ((1 << SW) - 1);
        return (m >= (1 << (SW - 1))) ? m - (1 << SW) : m;
    endfunction

    // Cell score is the best of the three candidate moves; symbol marks the winners.
    function automatic void ref_cell(input int d, input int u, input int l, input bit m,
                                     output logic [2:0] sym, output int best);
        int c[3];
        c[0] = wrap(d + (m ? 1 : -1));
        c[1] = wrap(u - 1);
        c[2] = wrap(l - 1);
        best = c[0];
        for (int x = 1; x < 3; x++) if (c[x] > best) best = c[x];
        sym = 3'b000;
        for (int x = 0; x < 3; x++) if (c[x] == best) sym[x] = 1'b1;
`ifndef DIR_MULTIHOT_EN
        sym = sym & (3'(~sym) + 3'd1);
`endif
    endfunction

    task automatic chk_zero(input string pfx);
        chk({pfx, "_in_ready"}, int'(in_ready), 0);
        chk({pfx, "_we"}, int'(we), 0);
        chk({pfx, "_symbol"}, int'(symbol), 0);
        chk({pfx, "_score"}, int'(score_out), 0);
        chk({pfx, "_addr_i"}, int'(addr_i), 0);
        chk({pfx, "_addr_j"}, int'(addr_j), 0);
        chk({pfx, "_i_f"}, int'(i_f), 0);
        chk({pfx, "_j_f"}, int'(j_f), 0);
        chk({pfx, "_end_f"}, int'(end_f), 0);
    endtask

    task automatic do_reset();
        en_fill  = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic scan(input int pct, input int abort_at);
        exp_t q[$];
        exp_t e;
        int k = 0;
        int kk;
        int last_due = -100;
        int a_cyc = -1;
        int fin = -1;
        int t0;
        int b, d, u, l;
        bit rdy = 1'b0;
        bit aborted = 1'b0;
        bit m, v, acc;
        logic [2:0] s;
        en_fill  = 1'b1;
        in_valid = 1'b0;
        step();
        rdy = 1'b1;
        t0 = cyc;
        while (fin < 0 || cyc < fin + 3) begin
            if (cyc - t0 > 300) begin
                chk("scan_timeout", 1, 0);
                break;
            end
            chk("scan_ready", int'(in_ready), int'(rdy));
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("scan_we", int'(we), 1);
                chk("scan_sym", int'(symbol), int'(e.sym));
                chk("scan_score", int'(score_out), e.score);
                chk("scan_addr_i", int'(addr_i), e.ai);
                chk("scan_addr_j", int'(addr_j), e.aj);
            end else begin
                chk("scan_we_idle", int'(we), 0);
                chk("scan_sym_idle", int'(symbol), 0);
            end
            kk = (k < N * N) ? k : N * N - 1;
            if (aborted && fin >= 0 && cyc >= fin) begin
                chk("scan_if_clr", int'(i_f), 0);
                chk("scan_jf_clr", int'(j_f), 0);
            end else begin
                chk("scan_if", int'(i_f), kk / N + 1);
                chk("scan_jf", int'(j_f), kk % N + 1);
            end
            chk("scan_end_f", int'(end_f), int'(!aborted && fin >= 0 && cyc >= fin));

            if (!aborted && abort_at >= 0 && k == abort_at) begin
                en_fill = 1'b0;
                aborted = 1'b1;
                a_cyc   = cyc;
            end
            d = wrap(int'($urandom_range(0, 1023)));
            u = wrap(int'($urandom_range(0, 1023)));
            l = wrap(int'($urandom_range(0, 1023)));
            m = 1'($urandom_range(0, 1));
            v = (int'($urandom_range(1, 100)) <= pct);
            score_diag = SW'(d);
            score_up   = SW'(u);
            score_left = SW'(l);
            match      = m;
            in_valid   = v;
            acc = rdy && v;
            if (acc) begin
                ref_cell(d, u, l, m, s, b);
                e.due = cyc + 2;
                e.ai = k / N;
                e.aj = k % N;
                e.sym = s;
                e.score = b;
                q.push_back(e);
                last_due = cyc + 2;
                k++;
                if (k == N * N) fin = cyc + 3;
            end
            if (aborted || k == N * N) rdy = 1'b0;
            if (aborted) fin = (last_due + 1 > a_cyc + 2) ? last_due + 1 : a_cyc + 2;
            step();
        end
        in_valid = 1'b0;
        if (!aborted) begin
            en_fill = 1'b0;
            step();
            chk("scan_end_f_clear", int'(end_f), 0);
            chk("scan_if_clear", int'(i_f), 0);
            chk("scan_jf_clear", int'(j_f), 0);
            chk("scan_ready_idle", int'(in_ready), 0);
        end
    endtask

    initial begin
        vt[0] = '{0, 0, 0, 1'b1, 3'b001, 3'b001, 1};
        vt[1] = '{0, 0, -3, 1'b0, 3'b001, 3'b011, -1};
        vt[2] = '{-1, -1, 5, 1'b0, 3'b100, 3'b100, 4};
        vt[3] = '{3, 10, 2, 1'b1, 3'b010, 3'b010, 9};
        vt[4] = '{1, 1, 1, 1'b0, 3'b001, 3'b111, 0};
        vt[5] = '{-5, 2, 2, 1'b1, 3'b010, 3'b110, 1};
        vt[6] = '{511, -512, 0, 1'b1, 3'b010, 3'b010, 511};
        vt[7] = '{-100, -50, -60, 1'b0, 3'b010, 3'b010, -51};

        // reset held with en_fill high
        en_fill = 1'b1;
        step();
        step();
        chk_zero("rst0");
        en_fill = 1'b0;
        rst = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            do_reset();
            en_fill = 1'b1;
            step();
            chk("vec_ready", int'(in_ready), 1);
            score_diag = SW'(vt[v].d);
            score_up   = SW'(vt[v].u);
            score_left = SW'(vt[v].l);
            match      = vt[v].m;
            in_valid   = 1'b1;
            step();
            in_valid = 1'b0;
            chk("vec_we_early", int'(we), 0);
            chk("vec_if", int'(i_f), 1);
            chk("vec_jf", int'(j_f), 2);
            step();
            chk("vec_we", int'(we), 1);
`ifdef DIR_MULTIHOT_EN
            chk("vec_sym", int'(symbol), int'(vt[v].symm));
`else
            chk("vec_sym", int'(symbol), int'(vt[v].sym1));
`endif
            chk("vec_score", int'(score_out), vt[v].score);
            chk("vec_addr_i", int'(addr_i), 0);
            chk("vec_addr_j", int'(addr_j), 0);
            step();
            chk("vec_we_pulse", int'(we), 0);
            chk("vec_sym_clear", int'(symbol), 0);
            chk("vec_score_hold", int'(score_out), vt[v].score);
            en_fill = 1'b0;
        end

        do_reset();
        scan(100, -1);
        scan(60, -1);
        scan(50, 7);
        scan(40, -1);
        scan(70, 0);
        scan(100, -1);

        // reset in the middle of a fill with writes in flight
        do_reset();
        en_fill = 1'b1;
        step();
        in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            score_diag = SW'(n);
            score_up   = SW'(-n);
            score_left = SW'(2 * n);
            match      = 1'b1;
            step();
        end
        chk("mid_we_before", int'(we), 1);
        chk("mid_jf_before", int'(j_f), 2);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        en_fill = 1'b0;
        #3;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("mid_we_after", int'(we), 0);
            chk("mid_ready_after", int'(in_ready), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
